// File: rtl/key_scan_arb.sv
`default_nettype none
// ============================================================================
// Module      : key_scan_arb
// Description : Debounce and auto-repeat for a bank of active-low keys. A
//               single timer is shared round-robin across the bank.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scan_arb #(
    parameter int unsigned N_KEY    = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned DEB_CYC  = 500_000,
    parameter int unsigned HOLD_CYC = 25_000_000,
    parameter int unsigned REP_CYC  = 5_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_KEY-1:0] key,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDW-1:0]   evt_id,
    output logic             evt_rep,
    output logic             busy
);

    localparam logic [1:0] c_scan = 2'd0;
    localparam logic [1:0] c_deb  = 2'd1;
    localparam logic [1:0] c_emit = 2'd2;
    localparam logic [1:0] c_hold = 2'd3;

    localparam logic [31:0] c_deb_last  = 32'(DEB_CYC - 1);
    localparam logic [31:0] c_hold_last = 32'(HOLD_CYC - 1);
    localparam logic [31:0] c_rep_last  = 32'(REP_CYC - 1);
    localparam logic [IDW-1:0] c_last_id = IDW'(N_KEY - 1);

    logic [N_KEY-1:0] r_meta;
    logic [N_KEY-1:0] r_ks;
    logic [1:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_g;
    logic [31:0]      r_cnt;
    logic             r_use_rep;
    logic             r_valid;
    logic             r_rep;
    logic             r_busy;

    logic             w_hit;
    logic [IDW-1:0]   w_sel;
    logic [IDW-1:0]   w_g_next;
    logic             w_rel;
    logic [31:0]      w_hold_last;

    function automatic int f_wrap(input int a);
        return a % int'(N_KEY);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_ks   <= '1;
        end else begin
            r_meta <= key;
            r_ks   <= r_meta;
        end
    end

    // Walk offsets from the far end down so the nearest pressed key after
    // the pointer is the last assignment and therefore wins.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = int'(N_KEY) - 1; i >= 0; i--) begin
            if (!r_ks[IDW'(f_wrap(int'(r_ptr) + i))]) begin
                w_hit = 1'b1;
                w_sel = IDW'(f_wrap(int'(r_ptr) + i));
            end
        end
    end

    assign w_rel       = r_ks[r_g];
    assign w_g_next    = (r_g == c_last_id) ? '0 : r_g + IDW'(1);
    assign w_hold_last = r_use_rep ? c_rep_last : c_hold_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_scan;
            r_ptr     <= '0;
            r_g       <= '0;
            r_cnt     <= '0;
            r_use_rep <= 1'b0;
            r_valid   <= 1'b0;
            r_rep     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                c_scan: begin
                    if (w_hit) begin
                        r_g     <= w_sel;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_deb;
                    end
                end
                c_deb: begin
                    if (w_rel) begin
                        r_ptr   <= w_g_next;
                        r_busy  <= 1'b0;
                        r_state <= c_scan;
                    end else if (r_cnt == c_deb_last) begin
                        r_rep   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= c_emit;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_emit: begin
                    // A release here is deliberately ignored: the event
                    // still goes out and the hold phase sees the release.
                    if (evt_ready) begin
                        r_valid   <= 1'b0;
                        r_cnt     <= '0;
                        r_use_rep <= r_rep;
                        r_state   <= c_hold;
                    end
                end
                c_hold: begin
                    if (w_rel) begin
                        r_ptr   <= w_g_next;
                        r_busy  <= 1'b0;
                        r_state <= c_scan;
                    end else if (r_cnt == w_hold_last) begin
                        r_rep   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= c_emit;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_scan;
                end
            endcase
        end
    end

    assign evt_valid = r_valid;
    assign evt_id    = r_g;
    assign evt_rep   = r_rep;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_key_scan_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_scan_arb
// Description : Directed bench for key_scan_arb with a countdown-based
//               reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_scan_arb;

    localparam int N_KEY    = 4;
    localparam int IDW      = 2;
    localparam int DEB_CYC  = 8;
    localparam int HOLD_CYC = 20;
    localparam int REP_CYC  = 10;

    localparam int M_IDLE = 0;
    localparam int M_DEB  = 1;
    localparam int M_OUT  = 2;
    localparam int M_WAIT = 3;

    logic             clk;
    logic             rst_n;
    logic [N_KEY-1:0] key;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDW-1:0]   evt_id;
    logic             evt_rep;
    logic             busy;

    int n_chk = 0;
    int n_err = 0;
    int n_hs  = 0;

    key_scan_arb #(
        .N_KEY(N_KEY), .IDW(IDW), .DEB_CYC(DEB_CYC),
        .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_id(evt_id), .evt_rep(evt_rep), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N_KEY-1:0] ks, input int ptr);
        for (int k = 0; k < N_KEY; k++)
            if (!ks[(ptr + k) % N_KEY]) return (ptr + k) % N_KEY;
        return -1;
    endfunction

    // Reference model: a phase plus a countdown of cycles left in it.
    int               m_mode, m_left, m_g, m_ptr;
    bit               m_rep;
    logic [N_KEY-1:0] m_s1, m_s2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_left <= 0; m_g <= 0; m_ptr <= 0; m_rep <= 1'b0;
            m_s1 <= '1; m_s2 <= '1;
        end else begin
            case (m_mode)
                M_IDLE: if (pick(m_s2, m_ptr) >= 0) begin
                    m_g <= pick(m_s2, m_ptr); m_mode <= M_DEB; m_left <= DEB_CYC - 1;
                end
                M_DEB: if (m_s2[m_g]) begin
                    m_mode <= M_IDLE; m_ptr <= (m_g + 1) % N_KEY;
                end else if (m_left == 0) begin
                    m_mode <= M_OUT; m_rep <= 1'b0;
                end else m_left <= m_left - 1;
                M_OUT: if (evt_ready) begin
                    m_mode <= M_WAIT; m_left <= (m_rep ? REP_CYC : HOLD_CYC) - 1;
                end
                default: if (m_s2[m_g]) begin
                    m_mode <= M_IDLE; m_ptr <= (m_g + 1) % N_KEY;
                end else if (m_left == 0) begin
                    m_mode <= M_OUT; m_rep <= 1'b1;
                end else m_left <= m_left - 1;
            endcase
            m_s1 <= key;
            m_s2 <= m_s1;
        end
    end

    always @(negedge clk) begin
        chk("valid", 32'(evt_valid), 32'(m_mode == M_OUT));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        if (m_mode == M_OUT) begin
            chk("id", 32'(evt_id), 32'(m_g));
            chk("rep", 32'(evt_rep), 32'(m_rep));
        end
        if (rst_n && evt_valid && evt_ready) n_hs++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Edges until evt_valid is seen high, bounded.
    task automatic wait_rise(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!evt_valid && n < 200);
    endtask

    int n, hs0;

    initial begin
        rst_n = 1'b0; key = '1; evt_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_rep", 32'(evt_rep), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #21 rst_n = 1'b1;
        tick(2);

        // Glitch on key 2: too short, no event, pointer moves to 3
        hs0 = n_hs;
        key[2] = 1'b0; tick(5); key[2] = 1'b1; tick(10);
        chk("glitch_events", 32'(n_hs - hs0), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd0);

        // Press and repeat on key 1
        hs0 = n_hs;
        key[1] = 1'b0;
        wait_rise(n); chk("first_lat", 32'(n), 32'd11);
        chk("first_id", 32'(evt_id), 32'd1);
        chk("first_rep", 32'(evt_rep), 32'd0);
        wait_rise(n); chk("rep1_lat", 32'(n), 32'd21);
        chk("rep1_rep", 32'(evt_rep), 32'd1);
        wait_rise(n); chk("rep2_lat", 32'(n), 32'd11);
        wait_rise(n); chk("rep3_lat", 32'(n), 32'd11);
        key[1] = 1'b1; tick(40);
        chk("press_events", 32'(n_hs - hs0), 32'd4);

        // Backpressure: ready low cycles 11..25
        hs0 = n_hs;
        evt_ready = 1'b0; key[1] = 1'b0;
        wait_rise(n); chk("bp_first_lat", 32'(n), 32'd11);
        tick(15);
        chk("bp_still_valid", 32'(evt_valid), 32'd1);
        chk("bp_id", 32'(evt_id), 32'd1);
        evt_ready = 1'b1;
        wait_rise(n); chk("bp_rep1_lat", 32'(n), 32'd21);
        key[1] = 1'b1; tick(40);
        chk("bp_events", 32'(n_hs - hs0), 32'd2);

        // Asynchronous reset while emitting
        evt_ready = 1'b0; key[2] = 1'b0;
        wait_rise(n);
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(evt_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        key = '1; evt_ready = 1'b1;
        #12 rst_n = 1'b1;
        tick(3);

        // Arbitration after reset: key 0 beats key 3
        key[0] = 1'b0; key[3] = 1'b0;
        wait_rise(n); chk("arb_lat", 32'(n), 32'd11);
        chk("arb_id0", 32'(evt_id), 32'd0);
        tick(3);
        key[0] = 1'b1;
        wait_rise(n); chk("arb_k3_lat", 32'(n), 32'd12);
        chk("arb_id3", 32'(evt_id), 32'd3);
        key[3] = 1'b1; tick(30);
        key[1] = 1'b0; key[3] = 1'b0;
        wait_rise(n);
        chk("ptr_wrap_id", 32'(evt_id), 32'd1);
        key = '1; tick(30);

        // Release during EMIT: delivered once, then back to scan
        hs0 = n_hs;
        evt_ready = 1'b0; key[2] = 1'b0;
        wait_rise(n);
        chk("rel_id", 32'(evt_id), 32'd2);
        key[2] = 1'b1; tick(6);
        evt_ready = 1'b1; tick(40);
        chk("rel_events", 32'(n_hs - hs0), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
